// File: rtl/multu_hilo_if.sv
// multu_hilo_if: operand, function-code and HI/LO result bundle for the multu_hilo multiplier.
interface multu_hilo_if;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dataOut;
    modport slave (input Signal, dataA, dataB, output busy, done, hi, lo, dataOut);
    modport master (output Signal, dataA, dataB, input busy, done, hi, lo, dataOut);
endinterface

// File: rtl/multu_hilo.sv
// multu_hilo: 32x32 unsigned shift-add multiplier with HI/LO commit on the open strobe.
// Optional macro MULTU_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module multu_hilo (
    input  logic         clk,
    input  logic         rst_n,
    multu_hilo_if.slave  bus
);
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] OPEN  = 6'b111111;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
    state_t      state_q, state_d;
    logic [63:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [31:0] mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d, last;
`ifdef MULTU_EARLY_EXIT_EN
    assign last = (cnt_q == 6'd31) || (mplier_q[31:1] == 31'd0);
`else
    assign last = cnt_q == 6'd31;
`endif
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.Signal == MULTU) begin
                mcand_d  = {32'b0, bus.dataA};
                mplier_d = bus.dataB;
                prod_d   = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                state_d  = last ? WAIT : RUN;
            end
            WAIT: if (bus.Signal == OPEN) begin
                hi_d    = prod_q[63:32];
                lo_d    = prod_q[31:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end
    assign bus.busy    = (state_q == RUN) || (state_q == WAIT);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.dataOut = bus.Signal == MFHI ? hi_q : bus.Signal == MFLO ? lo_q : 32'd0;
endmodule
